sequential_divider_18by9: RTL and testbench

SEQUENTIAL_DIVIDER_18BY9 -- requirements
Module: sequential_divider_18by9

---
 rtl/divider_pkg.sv | 24 ++
 rtl/div_restoring_step.sv | 35 +++
 rtl/sequential_divider_18by9.sv | 170 +++++++++++++++++
 tb/tb_sequential_divider_18by9.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// ============================================================================
// Module  : divider_pkg
// Brief   : Shared widths, iteration count and FSM state type for the
//           18-by-9 sequential divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package divider_pkg;

   localparam int DVD_WIDTH_DEF = 18;
   localparam int DVS_WIDTH_DEF = 9;
   localparam int ITER_COUNT    = 18;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/div_restoring_step.sv
// ============================================================================
// Module  : div_restoring_step
// Brief   : One radix-2 restoring iteration: shift in a dividend bit,
//           trial-subtract the divisor, keep or restore the partial remainder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_restoring_step
   import divider_pkg::*;
#(
   parameter int DVS_WIDTH = DVS_WIDTH_DEF
) (
   input  logic [DVS_WIDTH:0]   rem_in,
   input  logic                 dvd_bit,
   input  logic [DVS_WIDTH-1:0] dvs,
   output logic [DVS_WIDTH:0]   rem_out,
   output logic                 q_bit
);

   logic [DVS_WIDTH+1:0] trial;
   logic [DVS_WIDTH:0]   diff;

   // The extra trial MSB only matters for a zero divisor, where the partial
   // remainder is never reduced and keeps absorbing dividend bits.
   always_comb begin
      trial   = {rem_in, dvd_bit};
      diff    = trial[DVS_WIDTH:0] - {1'b0, dvs};
      q_bit   = (trial >= {2'b00, dvs});
      rem_out = q_bit ? diff : trial[DVS_WIDTH:0];
   end

endmodule

`default_nettype wire

// File: rtl/sequential_divider_18by9.sv
// ============================================================================
// Module  : sequential_divider_18by9
// Brief   : Signed/unsigned 18/9 restoring divider, valid/ready handshake.
//           DIVIDER_DIV0_FLAG_EN: zero divisor bypasses to DONE with a flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sequential_divider_18by9
   import divider_pkg::*;
#(
   parameter int DVD_WIDTH = DVD_WIDTH_DEF,
   parameter int DVS_WIDTH = DVS_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DVD_WIDTH-1:0] dividend,
   input  logic [DVS_WIDTH-1:0] divisor,
   input  logic                 A_sign,
   input  logic                 B_sign,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DVD_WIDTH-1:0] quotient,
   output logic [DVS_WIDTH-1:0] remainder,
   output logic                 div_zero
);

   localparam int CNT_W = $clog2(ITER_COUNT);

   state_t               state_q,     state_d;
   logic [CNT_W-1:0]     count_q,     count_d;
   logic [DVD_WIDTH-1:0] dvd_q,       dvd_d;
   logic [DVS_WIDTH-1:0] dvs_q,       dvs_d;
   logic [DVS_WIDTH:0]   rem_q,       rem_d;
   logic                 neg_quo_q,   neg_quo_d;
   logic                 neg_rem_q,   neg_rem_d;
   logic                 in_ready_q,  in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [DVD_WIDTH-1:0] quotient_q,  quotient_d;
   logic [DVS_WIDTH-1:0] remainder_q, remainder_d;
   logic                 div_zero_q,  div_zero_d;

   logic                 sdvd;
   logic                 sdvs;
   logic [DVS_WIDTH:0]   step_rem;
   logic                 step_q_bit;

   div_restoring_step #(
      .DVS_WIDTH (DVS_WIDTH)
   ) u_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_q[DVD_WIDTH-1]),
      .dvs     (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q_bit)
   );

   always_comb begin
      sdvd        = dividend[DVD_WIDTH-1] & A_sign;
      sdvs        = divisor[DVS_WIDTH-1] & B_sign;
      state_d     = state_q;
      count_d     = count_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dvd_d      = sdvd ? (~dividend + 1'b1) : dividend;
               dvs_d      = sdvs ? (~divisor + 1'b1) : divisor;
               neg_quo_d  = sdvd ^ sdvs;
               neg_rem_d  = sdvd;
               rem_d      = '0;
               count_d    = '0;
               in_ready_d = 1'b0;
               state_d    = S_CALC;
`ifdef DIVIDER_DIV0_FLAG_EN
               if (divisor == '0) begin
                  quotient_d  = '1;
                  remainder_d = dividend[DVS_WIDTH-1:0];
                  div_zero_d  = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            // Quotient bits shift into the vacated LSBs of the dividend register.
            rem_d   = step_rem;
            dvd_d   = {dvd_q[DVD_WIDTH-2:0], step_q_bit};
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(ITER_COUNT - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quotient_d  = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
            remainder_d = neg_rem_q ? (~rem_q[DVS_WIDTH-1:0] + 1'b1)
                                    : rem_q[DVS_WIDTH-1:0];
            div_zero_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
`ifdef DIVIDER_DIV0_FLAG_EN
   assign div_zero  = div_zero_q;
`else
   assign div_zero  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sequential_divider_18by9.sv
// ============================================================================
// Module  : tb_sequential_divider_18by9
// Brief   : Directed self-checking bench for sequential_divider_18by9.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sequential_divider_18by9;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] dividend;
   logic [8:0]  divisor;
   logic        A_sign;
   logic        B_sign;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] quotient;
   logic [8:0]  remainder;
   logic        div_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sequential_divider_18by9 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .A_sign    (A_sign),
      .B_sign    (B_sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands on a falling edge, let the next rising edge accept them,
   // then scramble the inputs and count cycles until out_valid appears.
   task automatic launch(input logic [17:0] a, input logic [8:0] b,
                         input logic as, input logic bs, output int lat);
      @(negedge clk);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      dividend = a;
      divisor  = b;
      A_sign   = as;
      B_sign   = bs;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 18'h2AAAA;
      divisor  = 9'h155;
      A_sign   = ~as;
      B_sign   = ~bs;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [17:0] a, input logic [8:0] b,
                         input logic as, input logic bs, input logic [17:0] eq,
                         input logic [8:0] er, input logic ez, input int elat);
      int lat;
      launch(a, b, as, bs, lat);
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      check({tag, "_quotient"}, 32'(quotient), 32'(eq));
      check({tag, "_remainder"}, 32'(remainder), 32'(er));
      check({tag, "_div_zero"}, 32'(div_zero), 32'(ez));
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      A_sign    = 1'b0;
      B_sign    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_remainder", 32'(remainder), 32'd0);
      check("reset_div_zero", 32'(div_zero), 32'd0);
      rst_n = 1'b1;

      run_op("u1000_7",   18'd1000,   9'd7,   1'b0, 1'b0, 18'd142,    9'd6,     1'b0, 20);
      run_op("s-1000_7",  18'h3FC18,  9'd7,   1'b1, 1'b1, 18'h3FF72,  9'h1FA,   1'b0, 20);
      run_op("s1000_-7",  18'd1000,   9'h1F9, 1'b1, 1'b1, 18'h3FF72,  9'd6,     1'b0, 20);
      run_op("s-1000_-7", 18'h3FC18,  9'h1F9, 1'b1, 1'b1, 18'd142,    9'h1FA,   1'b0, 20);
      run_op("u261144_7", 18'h3FC18,  9'd7,   1'b0, 1'b0, 18'd37306,  9'd2,     1'b0, 20);
      run_op("u262143_511", 18'h3FFFF, 9'h1FF, 1'b0, 1'b0, 18'd513,   9'd0,     1'b0, 20);
      run_op("ovf",       18'h20000,  9'h1FF, 1'b1, 1'b1, 18'h20000,  9'd0,     1'b0, 20);
`ifdef DIVIDER_DIV0_FLAG_EN
      run_op("u500_0",    18'd500,    9'd0,   1'b0, 1'b0, 18'h3FFFF,  9'h1F4,   1'b1, 1);
`else
      run_op("u500_0",    18'd500,    9'd0,   1'b0, 1'b0, 18'h3FFFF,  9'h1F4,   1'b0, 20);
`endif

      // Back-pressure in DONE with a competing request on the input.
      launch(18'd1000, 9'd7, 1'b0, 1'b0, lat);
      check("hold_latency", 32'(lat), 32'd20);
      dividend = 18'd55;
      divisor  = 9'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_quotient", 32'(quotient), 32'd142);
         check("hold_remainder", 32'(remainder), 32'd6);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("release_no_accept", 32'(in_ready), 32'd1);

      // Reset in the middle of CALC discards the operation.
      @(negedge clk);
      dividend = 18'd1000;
      divisor  = 9'd7;
      A_sign   = 1'b0;
      B_sign   = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      check("midrst_remainder", 32'(remainder), 32'd0);
      check("midrst_div_zero", 32'(div_zero), 32'd0);
      repeat (25) @(negedge clk);
      check("midrst_stays_idle", 32'(out_valid), 32'd0);
      run_op("post_rst", 18'd1000, 9'd7, 1'b0, 1'b0, 18'd142, 9'd6, 1'b0, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
